// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
// Receive-side checker for a VGA Hsync/Vsync pair. It measures line period,
// Hsync width, lines per frame and Vsync width in pixel clocks / lines, then
// judges every frame against the nominal timing and tracks lock.
//
// Ports:
//   CLK_40M    in   pixel clock, the only clock
//   RSTn       in   asynchronous reset, active-high despite the name
//   Hsync_sig  in   horizontal sync (active level H_POL)
//   Vsync_sig  in   vertical sync (active level V_POL)
//   Locked_sig out  LOCK_FRAMES consecutive good frames seen
//   Frame_ok   out  one-cycle pulse, frame passed
//   Frame_err  out  one-cycle pulse, frame failed
//   Lost_sig   out  one-cycle pulse, no Hsync leading edge for TIMEOUT clocks
//   H_period   out  last measured line period (clocks)
//   H_width    out  last measured Hsync width (clocks)
//   V_period   out  last measured lines per frame
//   Err_cnt    out  failed-frame count, saturating at 255
module vga_timing_monitor #(
  parameter int H_TOTAL     = 1056,
  parameter int H_SYNC      = 128,
  parameter int V_TOTAL     = 628,
  parameter int V_SYNC      = 4,
  parameter bit H_POL       = 1'b1,
  parameter bit V_POL       = 1'b1,
  parameter int LOCK_FRAMES = 3,
  parameter int TIMEOUT     = 2047
) (
  input  logic        CLK_40M,
  input  logic        RSTn,
  input  logic        Hsync_sig,
  input  logic        Vsync_sig,
  output logic        Locked_sig,
  output logic        Frame_ok,
  output logic        Frame_err,
  output logic        Lost_sig,
  output logic [10:0] H_period,
  output logic [10:0] H_width,
  output logic [10:0] V_period,
  output logic [7:0]  Err_cnt
);

  localparam logic [10:0] CNT_MAX   = 11'd2047;
  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
  localparam logic [10:0] TIMEOUT_C = 11'(TIMEOUT);
  localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);
  localparam logic [7:0]  ERR_MAX   = 8'd255;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // 11-bit counter step that sticks at full scale instead of wrapping
  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

  logic        h_samp_r, h_hist_r, v_samp_r, v_hist_r;
  logic        h_lead_s, h_trail_s, h_act_s;
  logic        v_lead_s, v_trail_s, v_act_s;
  logic [10:0] h_cnt_r, hw_cnt_r, line_cnt_r, vw_cnt_r, vw_cap_r;
  logic        h_valid_r, h_meas_r, h_arm_r, line_err_r;
  logic        timeout_s, line_err_now_s, frame_good_s;
  logic        ok_s, err_s;
  state_t      state_r, state_nxt_s;
  logic [3:0]  good_cnt_r, good_nxt_s;

  assign h_act_s   = (h_samp_r == H_POL);
  assign h_lead_s  = (h_samp_r == H_POL) && (h_hist_r != H_POL);
  assign h_trail_s = (h_samp_r != H_POL) && (h_hist_r == H_POL);
  assign v_act_s   = (v_samp_r == V_POL);
  assign v_lead_s  = (v_samp_r == V_POL) && (v_hist_r != V_POL);
  assign v_trail_s = (v_samp_r != V_POL) && (v_hist_r == V_POL);

  // An H edge in the same cycle re-arms the timer, so it takes precedence.
  assign timeout_s = h_arm_r && !h_lead_s && (h_cnt_r == TIMEOUT_C);

  // Line check uses the registered measurements, i.e. values captured before
  // this edge; h_meas_r guarantees H_period holds a real measurement.
  assign line_err_now_s = h_lead_s && h_valid_r && h_meas_r &&
                          ((H_period != H_TOTAL_C) || (H_width != H_SYNC_C));

  assign frame_good_s = (line_cnt_r == V_TOTAL_C) && (vw_cap_r == V_SYNC_C) &&
                        !line_err_r && !line_err_now_s;

  // Sample flop plus history flop for both syncs
  always_ff @(posedge CLK_40M or posedge RSTn) begin
    if (RSTn) begin
      h_samp_r <= ~H_POL;
      h_hist_r <= ~H_POL;
      v_samp_r <= ~V_POL;
      v_hist_r <= ~V_POL;
    end else begin
      h_samp_r <= Hsync_sig;
      h_hist_r <= h_samp_r;
      v_samp_r <= Vsync_sig;
      v_hist_r <= v_samp_r;
    end
  end

  // Horizontal measurement: line period, Hsync width, validity and timeout arming
  always_ff @(posedge CLK_40M or posedge RSTn) begin
    if (RSTn) begin
      h_cnt_r   <= 11'd0;
      hw_cnt_r  <= 11'd0;
      H_period  <= 11'd0;
      H_width   <= 11'd0;
      h_valid_r <= 1'b0;
      h_meas_r  <= 1'b0;
      h_arm_r   <= 1'b1;
    end else begin
      h_cnt_r  <= h_lead_s ? 11'd1 : sat_inc11(h_cnt_r);
      hw_cnt_r <= h_lead_s ? 11'd1 : (h_act_s ? sat_inc11(hw_cnt_r) : hw_cnt_r);
      if (h_lead_s && h_valid_r) begin
        H_period <= h_cnt_r;
      end
      if (h_trail_s) begin
        H_width <= hw_cnt_r;
      end
      if (timeout_s) begin
        h_valid_r <= 1'b0;
        h_meas_r  <= 1'b0;
        h_arm_r   <= 1'b0;
      end else if (h_lead_s) begin
        h_valid_r <= 1'b1;
        h_meas_r  <= h_meas_r | h_valid_r;
        h_arm_r   <= 1'b1;
      end
    end
  end

  // Vertical measurement: lines per frame, Vsync width and per-frame line-error flag
  always_ff @(posedge CLK_40M or posedge RSTn) begin
    if (RSTn) begin
      line_cnt_r <= 11'd0;
      vw_cnt_r   <= 11'd0;
      vw_cap_r   <= 11'd0;
      V_period   <= 11'd0;
      line_err_r <= 1'b0;
    end else begin
      if (v_lead_s) begin
        // A coincident H edge is the first line of the new frame
        V_period   <= line_cnt_r;
        line_cnt_r <= h_lead_s ? 11'd1 : 11'd0;
        vw_cnt_r   <= h_lead_s ? 11'd1 : 11'd0;
        line_err_r <= 1'b0;
      end else begin
        if (h_lead_s) begin
          line_cnt_r <= sat_inc11(line_cnt_r);
        end
        if (h_lead_s && v_act_s) begin
          vw_cnt_r <= sat_inc11(vw_cnt_r);
        end
        if (line_err_now_s) begin
          line_err_r <= 1'b1;
        end
      end
      if (v_trail_s) begin
        vw_cap_r <= vw_cnt_r;
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge CLK_40M or posedge RSTn) begin
    if (RSTn) begin
      state_r    <= ST_SEARCH;
      good_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      good_cnt_r <= good_nxt_s;
    end
  end

  // Lock FSM next state and frame verdict
  always_comb begin
    state_nxt_s = state_r;
    good_nxt_s  = good_cnt_r;
    ok_s        = 1'b0;
    err_s       = 1'b0;
    if (timeout_s) begin
      state_nxt_s = ST_SEARCH;
      good_nxt_s  = 4'd0;
    end else if (v_lead_s) begin
      case (state_r)
        ST_SEARCH: begin
          // First frame boundary only aligns the monitor; no verdict
          state_nxt_s = ST_CHECK;
          good_nxt_s  = 4'd0;
        end
        ST_CHECK: begin
          if (frame_good_s) begin
            ok_s       = 1'b1;
            good_nxt_s = good_cnt_r + 4'd1;
            if ((good_cnt_r + 4'd1) == LOCK_C) begin
              state_nxt_s = ST_LOCKED;
            end else begin
              state_nxt_s = ST_CHECK;
            end
          end else begin
            err_s       = 1'b1;
            good_nxt_s  = 4'd0;
            state_nxt_s = ST_CHECK;
          end
        end
        ST_LOCKED: begin
          if (frame_good_s) begin
            ok_s = 1'b1;
          end else begin
            err_s       = 1'b1;
            good_nxt_s  = 4'd0;
            state_nxt_s = ST_CHECK;
          end
        end
        default: begin
          state_nxt_s = ST_SEARCH;
          good_nxt_s  = 4'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Registered status outputs and saturating error counter
  always_ff @(posedge CLK_40M or posedge RSTn) begin
    if (RSTn) begin
      Frame_ok   <= 1'b0;
      Frame_err  <= 1'b0;
      Lost_sig   <= 1'b0;
      Locked_sig <= 1'b0;
      Err_cnt    <= 8'd0;
    end else begin
      Frame_ok   <= ok_s;
      Frame_err  <= err_s;
      Lost_sig   <= timeout_s;
      Locked_sig <= (state_nxt_s == ST_LOCKED);
      if (err_s && (Err_cnt != ERR_MAX)) begin
        Err_cnt <= Err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor with a scaled-down raster (24 clocks x 8 lines)
// so that hundreds of frames fit in a short run. Frames are described at line
// level (line count, Vsync lines, one optionally distorted line) and a
// frame-level reference model predicts verdicts, lock, loss and counters.
module tb_vga_timing_monitor;

  localparam int HT = 24;
  localparam int HS = 4;
  localparam int VT = 8;
  localparam int VS = 2;
  localparam int LF = 3;
  localparam int TO = 2047;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs  = 1'b0;
  logic        vs  = 1'b0;
  logic        locked, frame_ok, frame_err, lost;
  logic [10:0] h_period, h_width, v_period;
  logic [7:0]  err_cnt;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS),
    .H_POL(1'b1), .V_POL(1'b1), .LOCK_FRAMES(LF), .TIMEOUT(TO)
  ) dut (
    .CLK_40M(clk), .RSTn(rst), .Hsync_sig(hs), .Vsync_sig(vs),
    .Locked_sig(locked), .Frame_ok(frame_ok), .Frame_err(frame_err),
    .Lost_sig(lost), .H_period(h_period), .H_width(h_width),
    .V_period(v_period), .Err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse counters: every cycle a pulse output is high counts once
  int mon_ok = 0, mon_err = 0, mon_lost = 0;
  always @(negedge clk) begin
    if (frame_ok === 1'b1)  mon_ok   <= mon_ok + 1;
    if (frame_err === 1'b1) mon_err  <= mon_err + 1;
    if (lost === 1'b1)      mon_lost <= mon_lost + 1;
  end

  // Reference model state
  int m_ok = 0, m_err = 0, m_lost = 0, m_errcnt = 0, m_streak = 0;
  bit m_search = 1'b1, m_locked = 1'b0, m_prev_good = 1'b0;
  int m_lines_since_v = 0, m_vp = 0, m_hedges = 0;
  int frame_no = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_errcnt = 0; m_streak = 0; m_search = 1'b1; m_locked = 1'b0;
    m_lines_since_v = 0; m_vp = 0; m_hedges = 0;
  endtask

  // Frame boundary: judge the frame just completed unless resynchronising
  task automatic model_v_edge();
    if (m_search) begin
      m_search = 1'b0;
      m_streak = 0;
    end else if (m_prev_good) begin
      m_ok++;
      m_streak++;
      if (m_streak >= LF) m_locked = 1'b1;
    end else begin
      m_err++;
      if (m_errcnt < 255) m_errcnt++;
      m_streak = 0;
      m_locked = 1'b0;
    end
    m_vp = m_lines_since_v;
    m_lines_since_v = 0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " locked"}, locked, 0);
    check({tag, " frame_ok"}, frame_ok, 0);
    check({tag, " frame_err"}, frame_err, 0);
    check({tag, " lost"}, lost, 0);
    check({tag, " err_cnt"}, err_cnt, 0);
    check({tag, " h_period"}, h_period, 0);
    check({tag, " h_width"}, h_width, 0);
    check({tag, " v_period"}, v_period, 0);
  endtask

  task automatic checkpoint();
    check($sformatf("f%0d ok_pulses", frame_no), mon_ok, m_ok);
    check($sformatf("f%0d err_pulses", frame_no), mon_err, m_err);
    check($sformatf("f%0d lost_pulses", frame_no), mon_lost, m_lost);
    check($sformatf("f%0d locked", frame_no), locked, m_locked);
    check($sformatf("f%0d err_cnt", frame_no), err_cnt, m_errcnt);
    check($sformatf("f%0d h_period", frame_no), h_period, (m_hedges >= 2) ? HT : 0);
    check($sformatf("f%0d h_width", frame_no), h_width, (m_hedges >= 2) ? HS : 0);
    check($sformatf("f%0d v_period", frame_no), v_period, m_vp);
  endtask

  // One frame: nl lines, vsl Vsync lines, line bl drawn with period bp and
  // width bw; rst_at >= 0 pulses reset for one cycle at that frame clock.
  task automatic send_frame(input int nl, input int vsl, input int bl,
                            input int bp, input int bw, input int rst_at);
    int c, p, w;
    model_v_edge();
    c = 0;
    for (int l = 0; l < nl; l++) begin
      p = (l == bl) ? bp : HT;
      w = (l == bl) ? bw : HS;
      m_lines_since_v++;
      m_hedges++;
      for (int k = 0; k < p; k++) begin
        tick();
        hs = (k < w);
        vs = (l < vsl);
        if (c == 4) checkpoint();
        if (rst_at >= 0 && c == rst_at) begin
          #2;
          rst = 1'b1;
          #1;
          reset_checks($sformatf("f%0d async_rst", frame_no));
          model_reset();
        end
        if (rst_at >= 0 && c == rst_at + 1) rst = 1'b0;
        c++;
      end
    end
    m_prev_good = (nl == VT) && (vsl == VS) &&
                  ((bl < 0) || (bl >= nl) || ((bp == HT) && (bw == HS)));
    frame_no++;
  endtask

  task automatic nominal();
    send_frame(VT, VS, -1, HT, HS, -1);
  endtask

  // Both syncs idle long enough for the loss detector to fire exactly once
  task automatic hold(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      hs = 1'b0;
      vs = 1'b0;
      if (k == 1900) check("hold early_lost", mon_lost, m_lost);
    end
    m_lost++;
    m_locked = 1'b0;
    m_search = 1'b1;
    m_streak = 0;
    check("hold lost_once", mon_lost, m_lost);
    check("hold locked", locked, 0);
    check("hold err_cnt", err_cnt, m_errcnt);
  endtask

  initial begin
    int r, d;
    repeat (3) tick();
    reset_checks("por");
    rst = 1'b0;
    repeat (2) tick();

    // Acquire lock on a clean stream
    repeat (5) nominal();
    // One short line after lock, then relock
    send_frame(VT, VS, 2, HT - 1, HS, -1);
    repeat (4) nominal();
    // Vsync one line too long
    send_frame(VT, VS + 1, -1, HT, HS, -1);
    repeat (2) nominal();
    // Sync loss and resynchronisation
    hold(2300);
    repeat (5) nominal();
    // Reset mid-frame while locked (Hsync and Vsync both low at clock 84)
    send_frame(VT, VS, -1, HT, HS, 3 * HT + 12);
    repeat (5) nominal();

    // Randomised mix of clean and distorted frames
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 5);
      d = $urandom_range(1, 3);
      case (r)
        2: send_frame(VT, VS, 2, ($urandom_range(0, 1) == 1) ? HT + d : HT - d, HS, -1);
        3: send_frame(VT, VS, 2, HT, ($urandom_range(0, 1) == 1) ? HS + d : HS - (d % 2) - 1, -1);
        4: send_frame(VT, ($urandom_range(0, 1) == 1) ? VS + 1 : VS - 1, -1, HT, HS, -1);
        5: send_frame(($urandom_range(0, 1) == 1) ? VT + 1 : VT - 1, VS, -1, HT, HS, -1);
        default: nominal();
      endcase
    end
    nominal();

    // Error counter saturation
    repeat (300) send_frame(4, VS, -1, HT, HS, -1);
    nominal();
    check("err_cnt saturated", err_cnt, 255);
    check("locked after bad run", locked, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Receive-side checker for the VGA sync interface; taps the Hsync/Vsync pair driven by the sync generator.
- Measures line period, Hsync width, lines per frame and Vsync width, all synchronous to the pixel clock.
- Compares each measurement against the 800x600@60 timing and reports per-frame pass/fail, lock status and loss of sync.
- Used in-system as a sanity monitor and in benches as the scoreboard for any sync generator.

Parameters:
- H_TOTAL, 1056, clocks per line
- H_SYNC, 128, Hsync active width in clocks
- V_TOTAL, 628, lines per frame
- V_SYNC, 4, Vsync active width in lines
- H_POL, 1, Hsync active level
- V_POL, 1, Vsync active level
- LOCK_FRAMES, 3, consecutive good frames required to lock (1..15)
- TIMEOUT, 2047, clocks without an Hsync leading edge before sync is declared lost

Ports:
- CLK_40M in 1: pixel clock; the only clock.
- RSTn in 1: asynchronous reset, active-high (1 = reset).
- Hsync_sig in 1: horizontal sync, synchronous to CLK_40M.
- Vsync_sig in 1: vertical sync, synchronous to CLK_40M.
- Locked_sig out 1: timing locked.
- Frame_ok out 1: one-cycle pulse when a frame passes.
- Frame_err out 1: one-cycle pulse when a frame fails.
- Lost_sig out 1: one-cycle pulse on timeout.
- H_period out 11: last measured line period in clocks.
- H_width out 11: last measured Hsync width in clocks.
- V_period out 11: last measured lines per frame.
- Err_cnt out 8: failed-frame count, saturating at 255.

Behaviour:
- Reset: all outputs 0; state SEARCH; all counters 0; sync history registers set to the inactive level.
- Input path: one sample flop, then one history flop per sync. A leading edge is sample == active and history != active; a trailing edge is the inverse. Outputs react 2 clocks after the input pin changes.
- h_cnt (11 bits):
  - Loaded with 1 on an H leading edge; otherwise increments, saturating at 2047.
  - On an H leading edge with h_valid set, H_period <= h_cnt.
  - h_valid is set by the first H leading edge after reset or loss, so the first edge never produces a measurement.
- hw_cnt: loaded with 1 on an H leading edge, increments while Hsync is active. On an H trailing edge, H_width <= hw_cnt.
- Line check at each H leading edge with h_valid: a line error is flagged if H_period != H_TOTAL or H_width != H_SYNC. Because both values are registered, the check compares the values captured by the previous edge.
- line_cnt:
  - Increments on each H leading edge.
  - On a V leading edge, V_period <= line_cnt and line_cnt reloads to 1 if an H leading edge occurs in the same cycle, else 0. A coincident H edge therefore counts toward the new frame.
- vw_cnt: counts H leading edges while Vsync is active. Captured at the V trailing edge for the frame check.
- Frame verdict at each V leading edge, except the first after entering SEARCH:
  - Good = line_cnt == V_TOTAL, captured Vsync width == V_SYNC, and no line error in the frame. A line error detected in the same cycle counts.
  - Line-error flag clears after the verdict.
  - Frame_ok or Frame_err pulses on the cycle after the edge is detected.
- FSM:
  - SEARCH: on the first V leading edge, go to CHECK with good_cnt = 0; no verdict is issued.
  - CHECK: a good frame increments good_cnt; when good_cnt reaches LOCK_FRAMES, go to LOCKED and set Locked_sig. A bad frame clears good_cnt, stays in CHECK and increments Err_cnt.
  - LOCKED: a bad frame pulses Frame_err, clears Locked_sig, increments Err_cnt and returns to CHECK with good_cnt = 0.
- Timeout:
  - h_cnt reaching TIMEOUT in any state pulses Lost_sig once, clears Locked_sig and h_valid, and returns to SEARCH.
  - Err_cnt is not incremented.
  - No further Lost_sig until an H edge re-arms the timer.
- Reset asserted mid-frame: immediate return to reset values, with no verdict for the partial frame.
- Err_cnt: holds at 255, never wraps.

Test Plan:
- Nominal 1056x628 stream, sync widths 128/4, positive polarity → no verdict on the first V edge; Frame_ok on the next 3 V edges; Locked_sig = 1 after the 3rd; H_period = 1056, V_period = 628, Err_cnt = 0.
- After lock, shorten one line to 1055 clocks → Frame_err at that frame's closing V edge; Locked_sig = 0; Err_cnt = 1; relock after 3 further good frames.
- Vsync width 5 lines in one frame, locked → Frame_err; V_period still 628.
- Hold Hsync inactive after lock → Lost_sig pulses exactly once when h_cnt reaches 2047; state SEARCH; first resumed H edge gives no measurement.
- Assert RSTn for 1 cycle mid-frame while locked → all outputs 0 asynchronously; normal lock sequence repeats, first verdict at the 2nd V edge.
- Force 300 bad frames → Err_cnt saturates at 255.
